// File: rtl/max7219_pkg.sv
// Shared MAX7219 register addresses, sequencer/serializer state types and the hex font.
package max7219_pkg;

  localparam logic [3:0] ADDR_DECODE_MODE  = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY    = 4'hA;
  localparam logic [3:0] ADDR_SCAN_LIMIT   = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN     = 4'hC;
  localparam logic [3:0] ADDR_DISPLAY_TEST = 4'hF;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOW,
    TX_HIGH,
    TX_TAIL,
    TX_GAP
  } tx_state_e;

  typedef enum logic {
    SEQ_INIT,
    SEQ_REFRESH
  } seq_state_e;

  // Segment order DP,A,B,C,D,E,F,G with DP always off.
  function automatic logic [7:0] hex_font(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'h7E;
      4'h1: seg = 8'h30;
      4'h2: seg = 8'h6D;
      4'h3: seg = 8'h79;
      4'h4: seg = 8'h33;
      4'h5: seg = 8'h5B;
      4'h6: seg = 8'h5F;
      4'h7: seg = 8'h70;
      4'h8: seg = 8'h7F;
      4'h9: seg = 8'h7B;
      4'hA: seg = 8'h77;
      4'hB: seg = 8'h1F;
      4'hC: seg = 8'h4E;
      4'hD: seg = 8'h3D;
      4'hE: seg = 8'h4F;
      default: seg = 8'h47;
    endcase
    return seg;
  endfunction

  function automatic logic [15:0] make_word(input logic [3:0] addr, input logic [7:0] data);
    return {4'h0, addr, data};
  endfunction

endpackage

// File: rtl/max7219_if.sv
// Handshake between the display sequencer (master) and the SPI serializer (slave).
interface max7219_if #(
  parameter int NUM_CASCADES = 2
);
  logic                      start;
  logic [NUM_CASCADES*16-1:0] words;
  logic                      busy;
  logic                      spi_clk;
  logic                      dout;
  logic                      cs;

  modport master (output start, words, input busy, spi_clk, dout, cs);
  modport slave  (input start, words, output busy, spi_clk, dout, cs);
endinterface

// File: rtl/max7219_spi_tx.sv
// Shifts one NUM_CASCADES*16-bit word vector MSB first inside a single cs-low window,
// then holds cs high long enough that the next start lands exactly 2*SCLK_HALF later.
//   state   | meaning
//   TX_IDLE | cs high, waiting for start
//   TX_LOW  | cs low, spi_clk low, current bit on dout
//   TX_HIGH | spi_clk high, bit stable
//   TX_TAIL | cs low after last falling edge
//   TX_GAP  | cs high inter-transaction spacing
module max7219_spi_tx
  import max7219_pkg::*;
#(
  parameter int NUM_CASCADES = 2,
  parameter int SCLK_HALF    = 4
) (
  input logic      sysclk,
  input logic      reset,
  max7219_if.slave bus
);
  localparam int NBITS = NUM_CASCADES * 16;
  localparam int TW    = $clog2(2 * SCLK_HALF + 1);
  localparam int BW    = $clog2(NBITS);
  localparam logic [TW-1:0] HALF_LOAD = TW'(SCLK_HALF - 1);
  // The IDLE cycle that issues start is also a cs-high cycle, hence one short.
  localparam logic [TW-1:0] GAP_LOAD  = TW'(2 * SCLK_HALF - 2);
  localparam logic [BW-1:0] LAST_BIT  = BW'(NBITS - 1);

  tx_state_e        state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic             tc;

  assign tc = (timer_q == '0);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q   <= TX_IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = tc ? timer_q : timer_q - TW'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    unique case (state_q)
      TX_IDLE: begin
        if (bus.start) begin
          state_d   = TX_LOW;
          timer_d   = HALF_LOAD;
          bit_cnt_d = LAST_BIT;
          shift_d   = bus.words;
        end
      end
      TX_LOW: begin
        if (tc) begin
          state_d = TX_HIGH;
          timer_d = HALF_LOAD;
        end
      end
      TX_HIGH: begin
        if (tc) begin
          timer_d = HALF_LOAD;
          if (bit_cnt_q == '0) begin
            state_d = TX_TAIL;
          end else begin
            state_d   = TX_LOW;
            bit_cnt_d = bit_cnt_q - BW'(1);
            shift_d   = {shift_q[NBITS-2:0], 1'b0};
          end
        end
      end
      TX_TAIL: begin
        if (tc) begin
          state_d = TX_GAP;
          timer_d = GAP_LOAD;
        end
      end
      TX_GAP: begin
        if (tc) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign bus.spi_clk = (state_q == TX_HIGH);
  assign bus.cs      = !(state_q inside {TX_LOW, TX_HIGH, TX_TAIL});
  assign bus.dout    = (state_q inside {TX_LOW, TX_HIGH}) ? shift_q[NBITS-1] : 1'b0;
  assign bus.busy    = (state_q != TX_IDLE);

endmodule

// File: rtl/max7219_display.sv
// Drives a chain of MAX7219s: init sequence after reset, then endless digit 1..8 refresh.
// Define MAX7219_DEBUG_PINS_EN to mirror SPI lines and sequencer position on pin[10:1].
//   state       | meaning
//   SEQ_INIT    | sending init word idx (0..4)
//   SEQ_REFRESH | sending digit idx+1 (1..8)
module max7219_display
  import max7219_pkg::*;
#(
  parameter int NUM_CASCADES = 2,
  parameter int INTENSITY    = 1,
  parameter int SCLK_HALF    = 4
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [7:0]  frame [4*NUM_CASCADES],
  output logic        spi_clk,
  output logic        dout,
  output logic        cs,
  output logic        stop,
  output logic [10:1] pin
);
  localparam int NBITS = NUM_CASCADES * 16;

  max7219_if #(.NUM_CASCADES(NUM_CASCADES)) tx_bus ();

  seq_state_e       seq_state_q, seq_state_d;
  logic [2:0]       idx_q, idx_d;
  logic             start;
  logic [15:0]      init_word;
  logic [3:0]       digit_addr;
  logic [NBITS-1:0] digit_words;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      seq_state_q <= SEQ_INIT;
      idx_q       <= '0;
    end else begin
      seq_state_q <= seq_state_d;
      idx_q       <= idx_d;
    end
  end

  always_comb begin
    seq_state_d = seq_state_q;
    idx_d       = idx_q;
    start       = 1'b0;
    if (!tx_bus.busy) begin
      start = 1'b1;
      if (seq_state_q == SEQ_INIT && idx_q == 3'd4) begin
        seq_state_d = SEQ_REFRESH;
        idx_d       = '0;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end
  end

  always_comb begin
    init_word = make_word(ADDR_SHUTDOWN, 8'h01);
    case (idx_q)
      3'd1:    init_word = make_word(ADDR_DECODE_MODE, 8'h00);
      3'd2:    init_word = make_word(ADDR_SCAN_LIMIT, 8'h07);
      3'd3:    init_word = make_word(ADDR_INTENSITY, {4'h0, 4'(INTENSITY)});
      3'd4:    init_word = make_word(ADDR_DISPLAY_TEST, 8'h00);
      default: ;
    endcase
  end

  assign digit_addr = {1'b0, idx_q} + 4'd1;

  // Chip k shows frame[4k..4k+3], digit 8 on the first byte's high nibble.
  for (genvar k = 0; k < NUM_CASCADES; k++) begin : g_chip
    logic [7:0] sel_byte;
    always_comb begin
      sel_byte = '0;
      case (idx_q[2:1])
        2'd0:    sel_byte = frame[4*k+3];
        2'd1:    sel_byte = frame[4*k+2];
        2'd2:    sel_byte = frame[4*k+1];
        default: sel_byte = frame[4*k];
      endcase
    end
    assign digit_words[16*k +: 16] =
      make_word(digit_addr, hex_font(idx_q[0] ? sel_byte[7:4] : sel_byte[3:0]));
  end

  // Words are latched by the serializer on start, so the frame is sampled as cs falls.
  assign tx_bus.start = start;
  assign tx_bus.words = (seq_state_q == SEQ_INIT) ? {NUM_CASCADES{init_word}} : digit_words;

  max7219_spi_tx #(
    .NUM_CASCADES(NUM_CASCADES),
    .SCLK_HALF   (SCLK_HALF)
  ) u_spi_tx (
    .sysclk(sysclk),
    .reset (reset),
    .bus   (tx_bus)
  );

  assign spi_clk = tx_bus.spi_clk;
  assign dout    = tx_bus.dout;
  assign cs      = tx_bus.cs;
  assign stop    = tx_bus.cs;

`ifdef MAX7219_DEBUG_PINS_EN
  logic pin_hold_q, pin_hold_d;
  assign pin_hold_d = reset;
  always_ff @(posedge sysclk) pin_hold_q <= pin_hold_d;
  // Blank the mirror during reset so pin reads zero like the other reset outputs.
  assign pin = pin_hold_q ? '0
             : {2'b00, (seq_state_q == SEQ_INIT), idx_q, stop, cs, dout, spi_clk};
`else
  assign pin = '0;
`endif

endmodule

// File: tb/tb_max7219_display.sv
// Scoreboard bench for max7219_display: expected 32-bit transactions are queued by the
// stimulus and compared by a monitor that deserializes dout on spi_clk rising edges.
`timescale 1ns/1ps
module tb_max7219_display;
  localparam int NC    = 2;
  localparam int SH    = 1;
  localparam int NBITS = NC * 16;

  localparam logic [31:0] EXP_INIT [5] = '{
    32'h0C01_0C01, 32'h0900_0900, 32'h0B07_0B07, 32'h0A01_0A01, 32'h0F00_0F00
  };
  // Digits 1..8 for frame 12,34,56,78 / AB x4, then digit 1 after frame[3] -> 7E.
  localparam logic [31:0] EXP_REF [9] = '{
    32'h011F_017F, 32'h0277_0270, 32'h031F_035F, 32'h0477_045B,
    32'h051F_0533, 32'h0677_0679, 32'h071F_076D, 32'h0877_0830,
    32'h011F_014F
  };

  logic        sysclk = 1'b0;
  logic        reset  = 1'b1;
  logic [7:0]  frame [4*NC];
  logic        stop;
  logic [10:1] pin;

  max7219_if #(.NUM_CASCADES(NC)) bus ();
  assign bus.start = 1'b0;
  assign bus.words = '0;
  assign bus.busy  = 1'b0;

  max7219_display #(
    .NUM_CASCADES(NC),
    .INTENSITY   (1),
    .SCLK_HALF   (SH)
  ) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .frame  (frame),
    .spi_clk(bus.spi_clk),
    .dout   (bus.dout),
    .cs     (bus.cs),
    .stop   (stop),
    .pin    (pin)
  );

  always #5 sysclk = ~sysclk;

  int          checks     = 0;
  int          failures   = 0;
  int          trans_done = 0;
  int          bits_now   = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor
  logic        prev_cs = 1'b1;
  logic        prev_clk = 1'b0;
  logic        first_after_rst = 1'b1;
  logic [31:0] shreg = '0;
  int          lead = 0, tail = 0, gap = 0;

  always @(negedge sysclk) begin
    if (reset) begin
      prev_cs = 1'b1; prev_clk = 1'b0; bits_now = 0; first_after_rst = 1'b1; gap = 0;
    end else begin
      if (bus.cs) begin
        check("idle_clk_dout", {30'b0, bus.spi_clk, bus.dout}, 32'd0);
        if (!prev_cs) begin
          check($sformatf("txn%0d_bits", trans_done + 1), bits_now, NBITS);
          check($sformatf("txn%0d_tail", trans_done + 1), tail, SH);
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL txn%0d_unexpected actual=%h required=none", trans_done + 1, shreg);
          end else begin
            check($sformatf("txn%0d_word", trans_done + 1), shreg, exp_q.pop_front());
          end
          trans_done++;
          gap = 0;
        end
        gap++;
      end else begin
        if (prev_cs) begin
          if (!first_after_rst) check("cs_gap", gap, 2 * SH);
          first_after_rst = 1'b0;
          bits_now = 0; shreg = '0; lead = 0; tail = 0;
        end
        if (bus.spi_clk && !prev_clk) begin
          if (bits_now == 0) check("cs_lead", lead, SH);
          shreg = {shreg[30:0], bus.dout};
          bits_now++;
        end else if (bus.spi_clk && prev_clk) begin
          check("dout_stable_high", {31'b0, bus.dout}, {31'b0, shreg[0]});
        end else if (!bus.spi_clk) begin
          if (bits_now == 0) lead++;
          else if (bits_now == NBITS) tail++;
        end
      end
      prev_cs  = bus.cs;
      prev_clk = bus.spi_clk;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_spi_clk"}, {31'b0, bus.spi_clk}, 32'd0);
    check({tag, "_cs"},      {31'b0, bus.cs},      32'd1);
    check({tag, "_dout"},    {31'b0, bus.dout},    32'd0);
    check({tag, "_stop"},    {31'b0, stop},        32'd1);
    check({tag, "_pin"},     {22'b0, pin},         32'd0);
  endtask

  task automatic wait_trans(input int n);
    int t = 0;
    while (trans_done < n && t < 5000) begin
      @(negedge sysclk);
      t++;
    end
    check($sformatf("reach_txn%0d", n), trans_done, n);
  endtask

  task automatic wait_bit(input int n);
    int t = 0;
    while (!(bus.cs == 1'b0 && bits_now == n) && t < 5000) begin
      @(negedge sysclk);
      t++;
    end
    check($sformatf("reach_bit%0d", n), bits_now, n);
  endtask

  initial begin
    frame = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAB, 8'hAB, 8'hAB, 8'hAB};
    reset = 1'b1;
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    check_reset_outputs("por");

    foreach (EXP_INIT[i]) exp_q.push_back(EXP_INIT[i]);
    foreach (EXP_REF[i])  exp_q.push_back(EXP_REF[i]);
    reset = 1'b0;

    // Change frame[3] in the middle of the first digit-1 transaction.
    wait_trans(5);
    wait_bit(4);
    frame[3] = 8'h7E;

    // Abort the digit-2 transaction after the second digit-1 during bit 10.
    wait_trans(14);
    wait_bit(10);
    exp_q.delete();
    reset = 1'b1;
    @(negedge sysclk);
    check_reset_outputs("abort");
    repeat (2) @(negedge sysclk);
    check_reset_outputs("abort_hold");

    foreach (EXP_INIT[i]) exp_q.push_back(EXP_INIT[i]);
    reset = 1'b0;
    wait_trans(19);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/max7219_display.md
MAX7219_DISPLAY -- requirements
Module: max7219_display

Interface
REQ-001 SHALL have parameter NUM_CASCADES, default 2: number of MAX7219 devices daisy-chained on one SPI line.
REQ-002 SHALL have parameter INTENSITY, default 1: 4-bit brightness value written to register 0xA.
REQ-003 SHALL have parameter SCLK_HALF, default 4: sysclk cycles per spi_clk half period, minimum 1.
REQ-004 SHALL have port sysclk, input, 1 bit: clock.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port frame, input, unpacked array of 4*NUM_CASCADES entries of 8 bits each: bytes to display.
REQ-007 SHALL have port spi_clk, output, 1 bit: MAX7219 CLK.
REQ-008 SHALL have port dout, output, 1 bit: MAX7219 DIN.
REQ-009 SHALL have port cs, output, 1 bit: MAX7219 LOAD/CS, active low.
REQ-010 SHALL have port stop, output, 1 bit: high while no transaction is in progress (cs high).
REQ-011 SHALL have port pin, output, bits [10:1]: debug mirror.

Function
REQ-012 SHALL send each transaction as one cs-low window of NUM_CASCADES*16 bits, MSB first. Each 16-bit word is {4'h0, addr[3:0], data[7:0]}. The word for the chip farthest from the FPGA goes first; the word for chip 0 (wired to dout) goes last.
REQ-013 SHALL time each bit as follows: dout changes only while spi_clk is low; spi_clk is low for SCLK_HALF cycles, then high for SCLK_HALF cycles.
REQ-014 SHALL drop cs one SCLK_HALF before the first rising edge of spi_clk.
REQ-015 SHALL raise cs SCLK_HALF after the last falling edge of spi_clk. spi_clk SHALL be low whenever cs is high.
REQ-016 SHALL hold cs high for 2*SCLK_HALF cycles between consecutive transactions.
REQ-017 SHALL send the init sequence after reset, with the same word to every chip, in this order: 0x0C01 (normal operation), 0x0900 (no decode), 0x0B07 (scan 8 digits), 0x0A0v (v = INTENSITY[3:0]), 0x0F00 (display test off).
REQ-018 SHALL, after init, refresh digits 1..8 in order and repeat forever. Digit d uses register address d.
REQ-019 SHALL map frame bytes as follows for chip k:
- digit 8 = frame[4k][7:4], digit 7 = frame[4k][3:0]
- digit 6 = frame[4k+1][7:4], digit 5 = frame[4k+1][3:0]
- and so on, through digit 1 = frame[4k+3][3:0].
REQ-020 SHALL convert each nibble to segments with DP=0 and bit order DP,A,B,C,D,E,F,G. Font, nibbles 0..F: 7E 30 6D 79 33 5B 5F 70 7F 7B 77 1F 4E 3D 4F 47.
REQ-021 SHALL sample the frame bytes needed for a refresh transaction in the cycle cs falls. Input changes during the transaction SHALL NOT alter it.
REQ-022 SHALL hold dout=0 while cs is high.

Reset
REQ-023 SHALL, in the cycle after reset is sampled high, drive spi_clk=0, dout=0, cs=1, stop=1 and pin=0.
REQ-024 SHALL abort any transaction in progress on reset, mid-bit included, and hold the outputs of REQ-023 while reset is high.
REQ-025 SHALL restart at the first init word once reset is released.

Configuration
REQ-026 SHALL, with MAX7219_DEBUG_PINS_EN defined, drive:
- pin[1]=spi_clk, pin[2]=dout, pin[3]=cs, pin[4]=stop
- pin[7:5] = current digit/init index
- pin[8] = init phase active
- pin[10:9] = 0
REQ-027 SHALL, without MAX7219_DEBUG_PINS_EN, drive pin to constant 0.

Structure
REQ-028 SHALL place the register address constants (0x9, 0xA, 0xB, 0xC, 0xF) and the 16-entry hex font function in shared package max7219_pkg.
REQ-029 SHALL implement the serializer as sub-module max7219_spi_tx. It takes a start strobe and a NUM_CASCADES*16-bit word vector, produces spi_clk, dout and cs, and reports busy. The sequencer and frame mapping SHALL stay in max7219_display.

Verification
REQ-030 SHALL cover reset: assert reset for 3 cycles -> spi_clk=0, cs=1, dout=0, stop=1, pin=0 on the next cycle.
REQ-031 SHALL cover the first transaction (NUM_CASCADES=2, SCLK_HALF=1) -> 32 rising edges of spi_clk carrying 0x0C01_0C01, then cs high.
REQ-032 SHALL cover the init order -> transactions 2..5 carry 0x0900_0900, 0x0B07_0B07, 0x0A01_0A01, 0x0F00_0F00.
REQ-033 SHALL cover the first refresh: frame[0..3]=12,34,56,78 and frame[4..7]=AB -> transaction 6 carries 0x011F_017F. Digit 8 later carries 0x0877_0830.
REQ-034 SHALL cover a frame[3] change from 78 to 7E while the digit-1 transaction is in progress -> that transaction is unchanged, and the next digit-1 carries 0x011F_014F.
REQ-035 SHALL cover reset pulsed during bit 10 of a refresh -> cs high the next cycle, and the next transaction is 0x0C01_0C01.
